// File: rtl/counter_monitor_if.sv
// counter_monitor_if
//   Groups the observed counter bus, the compare value, the interrupt
//   handshake and the status outputs of counter_monitor.
//   master : drives EN, C, CMP, IRQ_ACK; observes the status outputs
//   slave  : the monitor; samples the inputs and drives the status outputs
//   EN        monitor enable
//   C         counter value being observed
//   CMP       compare value
//   IRQ_ACK   interrupt acknowledge (level)
//   MATCH     one-cycle pulse, C entered CMP
//   WRAP      one-cycle pulse, C went all-ones -> zero
//   WRAP_CNT  saturating count of wraps since last accepted ack
//   CAPT      C value captured on the match that fired IRQ
//   IRQ       sticky interrupt
//   OVR       sticky overrun (match lost while FIRED or HOLD)
interface counter_monitor_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned WRAP_W = 4
);
  logic              EN;
  logic [WIDTH-1:0]  C;
  logic [WIDTH-1:0]  CMP;
  logic              IRQ_ACK;
  logic              MATCH;
  logic              WRAP;
  logic [WRAP_W-1:0] WRAP_CNT;
  logic [WIDTH-1:0]  CAPT;
  logic              IRQ;
  logic              OVR;

  modport master (
    output EN, C, CMP, IRQ_ACK,
    input  MATCH, WRAP, WRAP_CNT, CAPT, IRQ, OVR
  );

  modport slave (
    input  EN, C, CMP, IRQ_ACK,
    output MATCH, WRAP, WRAP_CNT, CAPT, IRQ, OVR
  );
endinterface

// File: rtl/counter_monitor.sv
// counter_monitor
//   Downstream observer of a WIDTH-bit counter value. Detects entry of the
//   counter into a programmable compare value and FF->00 wrap-around,
//   captures the count on the match that raises the interrupt, and runs an
//   acknowledge / hold-off handshake (IDLE -> ARMED -> FIRED -> HOLD).
//   All outputs are registered: C sampled at edge k is reflected after edge k.
// Ports
//   CLK      clock, rising edge
//   RESET_N  asynchronous active-low reset
//   bus      counter_monitor_if.slave (EN, C, CMP, IRQ_ACK in;
//            MATCH, WRAP, WRAP_CNT, CAPT, IRQ, OVR out)
module counter_monitor #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned WRAP_W  = 4,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic             CLK,
  input  logic             RESET_N,
  counter_monitor_if.slave bus
);

  // Hold-off counter must hold HOLDOFF; keep at least one bit when HOLDOFF<2.
  localparam int unsigned     HC_W      = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLDOFF);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(1);
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [WIDTH-1:0]  c_prev_q, c_prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic              match_q, match_d;
  logic              wrap_q, wrap_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [WIDTH-1:0]  capt_q, capt_d;
  logic              irq_q, irq_d;
  logic              ovr_q, ovr_d;

  logic entry;
  logic wrap_evt;
  logic ack_accept;

  // Event detection. Entry compares the previous sample against the current
  // CMP, so C sitting on CMP produces a single entry; with no valid previous
  // sample (first edge after reset) an equal C counts as an entry.
  always_comb begin
    entry      = (bus.C == bus.CMP) && (!prev_valid_q || (c_prev_q != bus.CMP));
    wrap_evt   = prev_valid_q && (c_prev_q == {WIDTH{1'b1}}) && (bus.C == '0);
    ack_accept = bus.EN && (state_q == FIRED) && bus.IRQ_ACK;
  end

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Next-state logic; EN low overrides every transition.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    if (!bus.EN) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE:  state_d = ARMED;
        ARMED: if (entry) state_d = FIRED;
        FIRED: begin
          if (bus.IRQ_ACK) begin
            if (HOLDOFF == 0) begin
              state_d = ARMED;
            end else begin
              state_d    = HOLD;
              hold_cnt_d = HOLD_LOAD;
            end
          end
        end
        HOLD: begin
          hold_cnt_d = hold_cnt_q - 1'b1;
          if (hold_cnt_q <= HOLD_LAST) begin
            state_d    = ARMED;
            hold_cnt_d = '0;
          end
        end
        default: begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  // Output / datapath logic
  always_comb begin
    c_prev_d     = bus.C;
    prev_valid_d = 1'b1;
    match_d      = bus.EN && entry;
    wrap_d       = bus.EN && wrap_evt;

    // Accepted ack clears the wrap count even if a wrap lands on the same edge.
    wrap_cnt_d = wrap_cnt_q;
    if (ack_accept) begin
      wrap_cnt_d = '0;
    end else if (wrap_d && (wrap_cnt_q != WRAP_MAX)) begin
      wrap_cnt_d = wrap_cnt_q + 1'b1;
    end

    capt_d = capt_q;
    if (bus.EN && (state_q == ARMED) && entry) begin
      capt_d = bus.C;
    end

    // A lost match sets OVR and takes priority over the ack clear.
    ovr_d = ovr_q;
    if (ack_accept) begin
      ovr_d = 1'b0;
    end
    if (match_d && ((state_q == FIRED) || (state_q == HOLD))) begin
      ovr_d = 1'b1;
    end

    irq_d = (state_d == FIRED);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      c_prev_q     <= '0;
      prev_valid_q <= 1'b0;
      match_q      <= 1'b0;
      wrap_q       <= 1'b0;
      wrap_cnt_q   <= '0;
      capt_q       <= '0;
      irq_q        <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      c_prev_q     <= c_prev_d;
      prev_valid_q <= prev_valid_d;
      match_q      <= match_d;
      wrap_q       <= wrap_d;
      wrap_cnt_q   <= wrap_cnt_d;
      capt_q       <= capt_d;
      irq_q        <= irq_d;
      ovr_q        <= ovr_d;
    end
  end

  assign bus.MATCH    = match_q;
  assign bus.WRAP     = wrap_q;
  assign bus.WRAP_CNT = wrap_cnt_q;
  assign bus.CAPT     = capt_q;
  assign bus.IRQ      = irq_q;
  assign bus.OVR      = ovr_q;

endmodule

// File: tb/tb_counter_monitor.sv
// tb_counter_monitor
//   Self-checking bench for counter_monitor (WIDTH=8, WRAP_W=4, HOLDOFF=2).
module tb_counter_monitor;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned WRAP_W  = 4;
  localparam int unsigned HOLDOFF = 2;

  typedef struct {
    string      tag;
    logic       en;
    logic [7:0] c;
    logic [7:0] cmp;
    logic       ack;
    logic       match;
    logic       wrap;
    logic [3:0] wcnt;
    logic [7:0] capt;
    logic       irq;
    logic       ovr;
  } vec_t;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t sb[$];
  vec_t tbl_a[$];
  vec_t tbl_b[$];

  counter_monitor_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) bus ();

  counter_monitor #(
    .WIDTH(WIDTH),
    .WRAP_W(WRAP_W),
    .HOLDOFF(HOLDOFF)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(string tag, logic en, logic [7:0] c, logic [7:0] cmp,
                              logic ack, logic m, logic w, logic [3:0] wc,
                              logic [7:0] capt, logic irq, logic ovr);
    vec_t v;
    v.tag = tag; v.en = en; v.c = c; v.cmp = cmp; v.ack = ack;
    v.match = m; v.wrap = w; v.wcnt = wc; v.capt = capt; v.irq = irq; v.ovr = ovr;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(vec_t e);
    chk({e.tag, ".MATCH"},    32'(bus.MATCH),    32'(e.match));
    chk({e.tag, ".WRAP"},     32'(bus.WRAP),     32'(e.wrap));
    chk({e.tag, ".WRAP_CNT"}, 32'(bus.WRAP_CNT), 32'(e.wcnt));
    chk({e.tag, ".CAPT"},     32'(bus.CAPT),     32'(e.capt));
    chk({e.tag, ".IRQ"},      32'(bus.IRQ),      32'(e.irq));
    chk({e.tag, ".OVR"},      32'(bus.OVR),      32'(e.ovr));
  endtask

  // Drive one sample, queue its expected result, compare after the edge.
  task automatic step(vec_t v);
    vec_t e;
    bus.EN = v.en; bus.C = v.c; bus.CMP = v.cmp; bus.IRQ_ACK = v.ack;
    sb.push_back(v);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      chk_outputs(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          tag    en  C      CMP    ack  M  W  WC  CAPT  IRQ OVR
    tbl_a.push_back(mk("a01", 1, 8'h2A, 8'h2A, 0, 1, 0, 0, 8'h00, 0, 0));
    tbl_a.push_back(mk("a02", 1, 8'h2A, 8'h2A, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl_a.push_back(mk("a03", 1, 8'h03, 8'h05, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl_a.push_back(mk("a04", 1, 8'h04, 8'h05, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl_a.push_back(mk("a05", 1, 8'h05, 8'h05, 0, 1, 0, 0, 8'h05, 1, 0));
    tbl_a.push_back(mk("a06", 1, 8'h05, 8'h05, 0, 0, 0, 0, 8'h05, 1, 0));
    tbl_a.push_back(mk("a07", 1, 8'h05, 8'h05, 0, 0, 0, 0, 8'h05, 1, 0));
    tbl_a.push_back(mk("a08", 1, 8'h06, 8'h05, 0, 0, 0, 0, 8'h05, 1, 0));
    tbl_a.push_back(mk("a09", 1, 8'h06, 8'h05, 1, 0, 0, 0, 8'h05, 0, 0));
    tbl_a.push_back(mk("a10", 1, 8'h05, 8'h05, 0, 1, 0, 0, 8'h05, 0, 1));
    tbl_a.push_back(mk("a11", 1, 8'h05, 8'h05, 0, 0, 0, 0, 8'h05, 0, 1));
    tbl_a.push_back(mk("a12", 1, 8'h06, 8'h07, 1, 0, 0, 0, 8'h05, 0, 1));
    tbl_a.push_back(mk("a13", 1, 8'h07, 8'h07, 0, 1, 0, 0, 8'h07, 1, 1));
    tbl_a.push_back(mk("a14", 1, 8'h08, 8'h07, 1, 0, 0, 0, 8'h07, 0, 0));
    tbl_a.push_back(mk("a15", 1, 8'h08, 8'h07, 0, 0, 0, 0, 8'h07, 0, 0));
    tbl_a.push_back(mk("a16", 1, 8'h08, 8'h07, 0, 0, 0, 0, 8'h07, 0, 0));
    tbl_a.push_back(mk("a17", 1, 8'h09, 8'h09, 0, 1, 0, 0, 8'h09, 1, 0));
    tbl_a.push_back(mk("a18", 1, 8'h0A, 8'h0A, 1, 1, 0, 0, 8'h09, 0, 1));
    tbl_a.push_back(mk("a19", 1, 8'h0A, 8'h0A, 0, 0, 0, 0, 8'h09, 0, 1));
    tbl_a.push_back(mk("a20", 1, 8'h0A, 8'h0A, 0, 0, 0, 0, 8'h09, 0, 1));
    tbl_a.push_back(mk("a21", 1, 8'h0B, 8'h0B, 0, 1, 0, 0, 8'h0B, 1, 1));
    tbl_a.push_back(mk("a22", 0, 8'h0C, 8'h0B, 0, 0, 0, 0, 8'h0B, 0, 1));
    tbl_a.push_back(mk("a23", 0, 8'h0B, 8'h0B, 0, 0, 0, 0, 8'h0B, 0, 1));
    tbl_a.push_back(mk("a24", 1, 8'h0B, 8'h0B, 0, 0, 0, 0, 8'h0B, 0, 1));
    tbl_a.push_back(mk("a25", 1, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h0B, 0, 1));
    tbl_a.push_back(mk("a26", 1, 8'h00, 8'h00, 0, 1, 1, 1, 8'h00, 1, 1));

    tbl_b.push_back(mk("b01", 1, 8'h00, 8'h55, 1, 0, 0, 0, 8'h00, 0, 0));
    tbl_b.push_back(mk("b02", 1, 8'h00, 8'h55, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl_b.push_back(mk("b03", 1, 8'h00, 8'h55, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl_b.push_back(mk("b04", 1, 8'h55, 8'h55, 0, 1, 0, 0, 8'h55, 1, 0));
    tbl_b.push_back(mk("b05", 1, 8'h56, 8'h55, 0, 0, 0, 0, 8'h55, 1, 0));
    tbl_b.push_back(mk("b06", 1, 8'h55, 8'h55, 0, 1, 0, 0, 8'h55, 1, 1));
    tbl_b.push_back(mk("b07", 1, 8'hFF, 8'h55, 0, 0, 0, 0, 8'h55, 1, 1));
    tbl_b.push_back(mk("b08", 1, 8'h00, 8'h55, 1, 0, 1, 0, 8'h55, 0, 0));
    tbl_b.push_back(mk("b09", 1, 8'h00, 8'h55, 0, 0, 0, 0, 8'h55, 0, 0));
    tbl_b.push_back(mk("b10", 1, 8'h00, 8'h55, 0, 0, 0, 0, 8'h55, 0, 0));
    tbl_b.push_back(mk("b11", 1, 8'h55, 8'h55, 0, 1, 0, 0, 8'h55, 1, 0));
    tbl_b.push_back(mk("b12", 1, 8'h56, 8'h55, 0, 0, 0, 0, 8'h55, 1, 0));
    tbl_b.push_back(mk("b13", 1, 8'h55, 8'h55, 0, 1, 0, 0, 8'h55, 1, 1));
    tbl_b.push_back(mk("b14", 1, 8'hFF, 8'h55, 0, 0, 0, 0, 8'h55, 1, 1));
    tbl_b.push_back(mk("b15", 1, 8'h00, 8'h55, 0, 0, 1, 1, 8'h55, 1, 1));

    bus.EN = 1'b0; bus.C = '0; bus.CMP = '0; bus.IRQ_ACK = 1'b0;
    #1;
    chk_outputs(mk("rst0", 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);

    foreach (tbl_a[i]) step(tbl_a[i]);

    // Sixteen more FF->00 wraps while FIRED: count saturates at 15.
    for (int i = 2; i <= 17; i++) begin
      step(mk($sformatf("wrapff%0d", i), 1, 8'hFF, 8'h55, 0, 0, 0,
              4'((i - 1) > 15 ? 15 : (i - 1)), 8'h00, 1, 1));
      step(mk($sformatf("wrap00_%0d", i), 1, 8'h00, 8'h55, 0, 0, 1,
              4'(i > 15 ? 15 : i), 8'h00, 1, 1));
    end

    foreach (tbl_b[i]) step(tbl_b[i]);

    // Asynchronous reset mid-cycle while FIRED with OVR set.
    #2;
    RESET_N = 1'b0;
    #1;
    chk_outputs(mk("rst_async", 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    @(posedge CLK);
    #1;
    chk_outputs(mk("rst_held", 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    @(negedge CLK);
    RESET_N = 1'b1;
    step(mk("c01", 1, 8'h10, 8'h20, 0, 0, 0, 0, 8'h00, 0, 0));
    step(mk("c02", 1, 8'h20, 8'h20, 0, 1, 0, 0, 8'h20, 1, 0));

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
